spike_fibre_builder: RTL and testbench

- Sits directly downstream of tppe: consumes the per-neuron TIMESTEPS-bit spike word (lif_output) for each output neuron of a layer.
- Repacks a layer row into the compressed format tppe consumes: a NUM_NEURONS-bit occupancy bitmask plus a dense fibre memory of nonzero spike words.
- The packed row becomes next-layer bitmask_a and fibre_a; fibre addresses are compacted indices, matching fibre_a_addr indexing.

---
 rtl/spike_fibre_builder_if.sv | 31 +++
 rtl/spike_fibre_builder.sv | 81 ++++++++
 tb/tb_spike_fibre_builder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_fibre_builder_if.sv
// Stream-side signals of spike_fibre_builder: spike beats in, fibre writes out,
// and the packed-row handshake (bitmask + nnz) towards the next layer.
interface spike_fibre_builder_if #(
  parameter int TIMESTEPS   = 16,
  parameter int NUM_NEURONS = 128,
  parameter int ADDR_WIDTH  = 8
);
  logic [TIMESTEPS-1:0]         spike_in;
  logic                         spike_valid;
  logic                         spike_ready;
  logic                         flush;
  logic                         fibre_wr_en;
  logic [ADDR_WIDTH-1:0]        fibre_wr_addr;
  logic [TIMESTEPS-1:0]         fibre_wr_data;
  logic [NUM_NEURONS-1:0]       bitmask_out;
  logic [$clog2(NUM_NEURONS):0] nnz_out;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output spike_in, spike_valid, flush, out_ready,
    input  spike_ready, fibre_wr_en, fibre_wr_addr, fibre_wr_data,
           bitmask_out, nnz_out, out_valid
  );

  modport slave (
    input  spike_in, spike_valid, flush, out_ready,
    output spike_ready, fibre_wr_en, fibre_wr_addr, fibre_wr_data,
           bitmask_out, nnz_out, out_valid
  );
endinterface

// File: rtl/spike_fibre_builder.sv
// Repacks one row of per-neuron spike words into an occupancy bitmask plus a
// dense fibre of the nonzero words, written at compacted addresses.
module spike_fibre_builder #(
  parameter int TIMESTEPS   = 16,
  parameter int NUM_NEURONS = 128,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spike_fibre_builder_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       neuron_idx;
  logic [CNT_W-1:0]       nnz_cnt;
  logic [NUM_NEURONS-1:0] bitmask;
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [TIMESTEPS-1:0]   wr_data;

  logic accept;
  logic last_beat;
  logic nonzero;

  assign accept    = bus.spike_valid && (state == COLLECT);
  assign last_beat = (neuron_idx == IDX_W'(NUM_NEURONS - 1));
  assign nonzero   = |bus.spike_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the bitmask is a plain register (not a RAM), so it is cleared by reset like the rest of the state.
      state      <= COLLECT;
      neuron_idx <= '0;
      nnz_cnt    <= '0;
      bitmask    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      // NOTE: non-blocking default makes wr_en a one-cycle strobe; later assignments in this block override it.
      wr_en <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            if (!last_beat) neuron_idx <= neuron_idx + IDX_W'(1);
            if (nonzero) begin
              bitmask[neuron_idx] <= 1'b1;
              nnz_cnt             <= nnz_cnt + CNT_W'(1);
              wr_en               <= 1'b1;
              wr_addr             <= ADDR_WIDTH'(nnz_cnt);
              wr_data             <= bus.spike_in;
            end
          end
          // A flush coinciding with a beat still commits that beat above.
          if ((accept && last_beat) || bus.flush) state <= EMIT;
        end
        EMIT: begin
          if (bus.out_ready) begin
            state      <= COLLECT;
            neuron_idx <= '0;
            nnz_cnt    <= '0;
            bitmask    <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.spike_ready   = (state == COLLECT);
  assign bus.out_valid     = (state == EMIT);
  assign bus.bitmask_out   = bitmask;
  assign bus.nnz_out       = nnz_cnt;
  assign bus.fibre_wr_en   = wr_en;
  assign bus.fibre_wr_addr = wr_addr;
  assign bus.fibre_wr_data = wr_data;
endmodule

// File: tb/tb_spike_fibre_builder.sv
// Self-checking bench for spike_fibre_builder: a directed vector table, corner
// sequences, and random traffic checked against a row-queue reference model.
module tb_spike_fibre_builder;
  localparam int T  = 16;
  localparam int NN = 128;
  localparam int AW = 8;

  typedef logic [NN-1:0] val_t;
  typedef logic [T-1:0]  word_t;

  typedef struct {
    bit    v;
    word_t d;
    bit    f;
    bit    r;
    bit    exp_wr;
    int    exp_addr;
    word_t exp_data;
    bit    exp_rdy;
    bit    exp_ov;
    int    exp_nnz;
    val_t  exp_mask;
  } vec_t;

  logic clk;
  logic rst_n;

  spike_fibre_builder_if #(.TIMESTEPS(T), .NUM_NEURONS(NN), .ADDR_WIDTH(AW)) bus ();

  spike_fibre_builder #(.TIMESTEPS(T), .NUM_NEURONS(NN), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the beats accepted so far in the current row, in order.
  word_t row_q[$];
  bit    m_emit;
  val_t  last_addr;
  val_t  last_data;

  task automatic check(input string name, input val_t act, input val_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int count_nz();
    int n = 0;
    foreach (row_q[i]) if (row_q[i] != '0) n++;
    return n;
  endfunction

  function automatic val_t model_mask();
    val_t m = '0;
    foreach (row_q[i]) if (row_q[i] != '0) m[i] = 1'b1;
    return m;
  endfunction

  // One clock: drive inputs, advance past the edge, update the model, compare.
  task automatic step(input bit v, input word_t d, input bit f, input bit r);
    bit acc;
    bit was_emit;
    bit exp_wr;
    int pre_nz;
    bus.spike_valid = v;
    bus.spike_in    = d;
    bus.flush       = f;
    bus.out_ready   = r;
    was_emit = m_emit;
    acc      = v && !m_emit;
    pre_nz   = count_nz();
    @(posedge clk);
    #1;
    if (!was_emit) begin
      if (acc) row_q.push_back(d);
      if (row_q.size() == NN || f) m_emit = 1'b1;
    end else if (r) begin
      m_emit = 1'b0;
      row_q.delete();
    end
    exp_wr = acc && (d != '0);
    if (exp_wr) begin
      last_addr = val_t'(pre_nz);
      last_data = val_t'(d);
    end
    check("wr_en", val_t'(bus.fibre_wr_en), val_t'(exp_wr));
    check("wr_addr", val_t'(bus.fibre_wr_addr), last_addr);
    check("wr_data", val_t'(bus.fibre_wr_data), last_data);
    check("spike_ready", val_t'(bus.spike_ready), val_t'(!m_emit));
    check("out_valid", val_t'(bus.out_valid), val_t'(m_emit));
    if (m_emit) begin
      check("bitmask", bus.bitmask_out, model_mask());
      check("nnz", val_t'(bus.nnz_out), val_t'(count_nz()));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, val_t'(bus.fibre_wr_en), '0);
    check({tag, "_wr_addr"}, val_t'(bus.fibre_wr_addr), '0);
    check({tag, "_wr_data"}, val_t'(bus.fibre_wr_data), '0);
    check({tag, "_bitmask"}, bus.bitmask_out, '0);
    check({tag, "_nnz"}, val_t'(bus.nnz_out), '0);
    check({tag, "_out_valid"}, val_t'(bus.out_valid), '0);
    check({tag, "_spike_ready"}, val_t'(bus.spike_ready), val_t'(1));
  endtask

  task automatic model_clear();
    row_q.delete();
    m_emit    = 1'b0;
    last_addr = '0;
    last_data = '0;
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    bus.spike_valid = 1'b0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_clear();
    #1 check_reset_outputs("rst_release");
  endtask

  function automatic vec_t mk(bit v, word_t d, bit f, bit r, bit wr, int a, word_t wd,
                              bit rdy, bit ov, int nnz, val_t mask);
    vec_t e;
    e.v = v; e.d = d; e.f = f; e.r = r;
    e.exp_wr = wr; e.exp_addr = a; e.exp_data = wd;
    e.exp_rdy = rdy; e.exp_ov = ov; e.exp_nnz = nnz; e.exp_mask = mask;
    return e;
  endfunction

  vec_t tbl[19];

  initial begin
    word_t w;
    val_t  m;

    // Partial row closed by flush, flush ignored in EMIT, flush with a beat, empty flush.
    tbl[0]  = mk(1, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 0, 0, '0);
    tbl[1]  = mk(1, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 0, 0, '0);
    tbl[2]  = mk(1, 16'h00A5, 0, 0, 1, 0, 16'h00A5, 1, 0, 0, '0);
    tbl[3]  = mk(0, 16'h1234, 0, 0, 0, 0, 16'h0000, 1, 0, 0, '0);
    for (int i = 4; i <= 10; i++) tbl[i] = mk(1, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 0, 0, '0);
    tbl[11] = mk(0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 1, 1, val_t'(4));
    tbl[12] = mk(1, 16'hFFFF, 1, 0, 0, 0, 16'h0000, 0, 1, 1, val_t'(4));
    tbl[13] = mk(0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 0, 0, '0);
    tbl[14] = mk(1, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 0, 0, '0);
    tbl[15] = mk(1, 16'h0F0F, 1, 0, 1, 0, 16'h0F0F, 0, 1, 1, val_t'(2));
    tbl[16] = mk(0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 0, 0, '0);
    tbl[17] = mk(0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 1, 0, '0);
    tbl[18] = mk(0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 0, 0, '0);

    rst_n           = 1'b0;
    bus.spike_valid = 1'b0;
    bus.spike_in    = '0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;
    model_clear();
    #1 check_reset_outputs("rst_init");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
      check($sformatf("tbl%0d_wr_en", i), val_t'(bus.fibre_wr_en), val_t'(tbl[i].exp_wr));
      if (tbl[i].exp_wr) begin
        check($sformatf("tbl%0d_addr", i), val_t'(bus.fibre_wr_addr), val_t'(tbl[i].exp_addr));
        check($sformatf("tbl%0d_data", i), val_t'(bus.fibre_wr_data), val_t'(tbl[i].exp_data));
      end
      check($sformatf("tbl%0d_ready", i), val_t'(bus.spike_ready), val_t'(tbl[i].exp_rdy));
      check($sformatf("tbl%0d_ovalid", i), val_t'(bus.out_valid), val_t'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) begin
        check($sformatf("tbl%0d_nnz", i), val_t'(bus.nnz_out), val_t'(tbl[i].exp_nnz));
        check($sformatf("tbl%0d_mask", i), bus.bitmask_out, tbl[i].exp_mask);
      end
    end

    // Sparse full row: neurons 0, 5, 127 nonzero.
    for (int i = 0; i < NN; i++) begin
      w = (i == 0) ? 16'h0001 : (i == 5) ? 16'h8000 : (i == 127) ? 16'hFFFF : 16'h0000;
      step(1, w, 0, 0);
    end
    m = '0;
    m[0] = 1'b1; m[5] = 1'b1; m[127] = 1'b1;
    check("sparse_last_wr", val_t'(bus.fibre_wr_en), val_t'(1));
    check("sparse_last_addr", val_t'(bus.fibre_wr_addr), val_t'(2));
    check("sparse_ovalid", val_t'(bus.out_valid), val_t'(1));
    check("sparse_mask", bus.bitmask_out, m);
    check("sparse_nnz", val_t'(bus.nnz_out), val_t'(3));
    step(0, '0, 0, 1);

    // Dense full row, then a long stall in EMIT with spike_valid held high.
    for (int i = 0; i < NN; i++) begin
      w = T'($urandom);
      if (w == '0) w = 16'h0001;
      step(1, w, 0, 0);
    end
    check("dense_mask", bus.bitmask_out, '1);
    check("dense_nnz", val_t'(bus.nnz_out), val_t'(NN));
    for (int i = 0; i < 20; i++) step(1, T'($urandom), i[0], 0);
    step(1, 16'h0042, 0, 1);
    check("stall_release_ready", val_t'(bus.spike_ready), val_t'(1));
    step(1, 16'h0042, 0, 0);
    check("next_row_addr0", val_t'(bus.fibre_wr_addr), '0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 1);

    // Ten beats with the flush on a nonzero tenth beat.
    for (int i = 0; i < 9; i++) step(1, (i == 2) ? 16'h0004 : 16'h0000, 0, 0);
    step(1, 16'h0200, 1, 0);
    m = '0;
    m[2] = 1'b1; m[9] = 1'b1;
    check("flushbeat_wr", val_t'(bus.fibre_wr_en), val_t'(1));
    check("flushbeat_addr", val_t'(bus.fibre_wr_addr), val_t'(1));
    check("flushbeat_mask", bus.bitmask_out, m);
    check("flushbeat_nnz", val_t'(bus.nnz_out), val_t'(2));
    step(0, '0, 0, 1);

    // Reset part-way through a row; the next row restarts at neuron 0, addr 0.
    for (int i = 0; i < 50; i++) step(1, ($urandom_range(0, 1) != 0) ? T'($urandom) : '0, 0, 0);
    mid_reset();
    step(1, 16'h0003, 1, 0);
    check("post_rst_addr", val_t'(bus.fibre_wr_addr), '0);
    check("post_rst_mask", bus.bitmask_out, val_t'(1));
    step(0, '0, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 9) < 7,
           ($urandom_range(0, 1) != 0) ? T'($urandom) : '0,
           $urandom_range(0, 199) == 0,
           $urandom_range(0, 1) != 0);
    end
    if (!m_emit) step(0, '0, 1, 0);
    step(0, '0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
